mem_access_controller: RTL and testbench

- Sequences every data-memory access issued by the MEM pipeline stage against a data RAM that handshakes with a ready signal and may take several cycles.
- Holds the pipeline with a stall while an access is in flight.
- Extracts and extends sub-word load data.
- Performs read-modify-write for byte and halfword stores.
- Detects misaligned and illegal requests and memory timeouts; sits between the MEM stage control/address path and the data RAM.

---
 rtl/mem_access_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_mem_access_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_controller.sv
// Data-memory access sequencer for the MEM pipeline stage.
// Drives a ready-handshaked data RAM. It stalls the pipeline while an access is
// in flight, formats sub-word loads, and does read-modify-write for sub-word
// stores. It flags misaligned or illegal requests and RAM timeouts.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_read, req_write    load / store request from MEM stage, held until done
//   req_addr, req_wdata    byte address, right-justified store data
//   load_mode              00 word, 01 half signed, 10 byte signed, 11 byte unsigned
//   store_mode             00 word, 01 half, 10 byte, 11 illegal
//   stall                  combinational pipeline hold
//   done, err              one-cycle completion / error pulses
//   load_data              formatted load result
//   mem_read, mem_write    RAM strobes (mutually exclusive)
//   mem_addr, mem_wdata    word-aligned RAM address and write data
//   mem_rdata, mem_ready   RAM read data and completion handshake
module mem_access_controller #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  load_mode,
    input  logic [1:0]  store_mode,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RMW_RD,
        RMW_WR,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_d, err_d, mem_read_d, mem_write_d;
    logic [31:0]       mem_addr_d, mem_wdata_d, load_data_d;

    logic              rd_misalign, wr_illegal, bad_req, legal_req, timeout_hit;

    // Pick the addressed lane(s) out of a RAM word and extend to 32 bits.
    function automatic logic [31:0] format_load(input logic [31:0] rdata,
                                                input logic [1:0]  mode,
                                                input logic [1:0]  lane);
        logic [15:0] half_v;
        logic [7:0]  byte_v;
        half_v = lane[1] ? rdata[31:16] : rdata[15:0];
        byte_v = rdata[{lane, 3'b000} +: 8];
        case (mode)
            2'b00:   format_load = rdata;
            2'b01:   format_load = {{16{half_v[15]}}, half_v};
            2'b10:   format_load = {{24{byte_v[7]}}, byte_v};
            default: format_load = {24'h000000, byte_v};
        endcase
    endfunction

    // Overlay the store lane(s) of wdata onto the word read back from RAM.
    function automatic logic [31:0] merge_store(input logic [31:0] rdata,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  mode,
                                                input logic [1:0]  lane);
        logic [31:0] res;
        res = rdata;
        if (mode == 2'b01) begin
            if (lane[1]) res[31:16] = wdata[15:0];
            else         res[15:0]  = wdata[15:0];
        end else begin
            res[{lane, 3'b000} +: 8] = wdata[7:0];
        end
        return res;
    endfunction

    // Request classification.
    always_comb begin
        case (load_mode)
            2'b00:   rd_misalign = (req_addr[1:0] != 2'b00);
            2'b01:   rd_misalign = req_addr[0];
            default: rd_misalign = 1'b0;
        endcase
        case (store_mode)
            2'b00:   wr_illegal = (req_addr[1:0] != 2'b00);
            2'b01:   wr_illegal = req_addr[0];
            2'b10:   wr_illegal = 1'b0;
            default: wr_illegal = 1'b1;
        endcase
        bad_req   = (req_read & req_write) | (req_read & rd_misalign) |
                    (req_write & wr_illegal);
        legal_req = (req_read | req_write) & ~bad_req;
    end

    // Last wait cycle before the access is abandoned.
    assign timeout_hit = (cnt_q == CNT_LAST);

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mem_read_d  = mem_read;
        mem_write_d = mem_write;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        load_data_d = load_data;
        stall       = 1'b0;

        case (state_q)
            IDLE: begin
                // The cycle after an err pulse is the pipeline-advance cycle.
                if (!err) begin
                    if (bad_req) begin
                        err_d = 1'b1;
                    end else if (legal_req) begin
                        stall      = 1'b1;
                        cnt_d      = '0;
                        mem_addr_d = {req_addr[31:2], 2'b00};
                        if (req_read) begin
                            state_d    = READ;
                            mem_read_d = 1'b1;
                        end else if (store_mode == 2'b00) begin
                            state_d     = WRITE;
                            mem_write_d = 1'b1;
                            mem_wdata_d = req_wdata;
                        end else begin
                            state_d    = RMW_RD;
                            mem_read_d = 1'b1;
                        end
                    end
                end
            end
            READ: begin
                stall = 1'b1;
                if (mem_ready) begin
                    load_data_d = format_load(mem_rdata, load_mode, req_addr[1:0]);
                    mem_read_d  = 1'b0;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end else if (timeout_hit) begin
                    mem_read_d = 1'b0;
                    done_d     = 1'b1;
                    err_d      = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WRITE, RMW_WR: begin
                stall = 1'b1;
                if (mem_ready || timeout_hit) begin
                    mem_write_d = 1'b0;
                    done_d      = 1'b1;
                    err_d       = ~mem_ready;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RMW_RD: begin
                stall = 1'b1;
                if (mem_ready) begin
                    mem_wdata_d = merge_store(mem_rdata, req_wdata, store_mode,
                                              req_addr[1:0]);
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = RMW_WR;
                end else if (timeout_hit) begin
                    mem_read_d = 1'b0;
                    done_d     = 1'b1;
                    err_d      = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase

        if (rst) stall = 1'b0;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            load_data <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            done      <= done_d;
            err       <= err_d;
            mem_read  <= mem_read_d;
            mem_write <= mem_write_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            load_data <= load_data_d;
        end
    end

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench for mem_access_controller with a latency-programmable RAM model.
module tb_mem_access_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_read, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  load_mode, store_mode;
    logic        stall, done, err, mem_read, mem_write, mem_ready;
    logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;

    mem_access_controller #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .load_mode(load_mode), .store_mode(store_mode),
        .stall(stall), .done(done), .load_data(load_data), .err(err),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // RAM model: ready after lat extra wait cycles (lat < 0 never answers).
    logic [31:0] ram [0:15];
    int          lat = 0;
    int          wcnt = 0;

    assign mem_rdata = ram[mem_addr[5:2]];
    assign mem_ready = (mem_read || mem_write) && (lat >= 0) && (wcnt == lat);

    always @(posedge clk) begin
        if (rst || mem_ready || !(mem_read || mem_write)) wcnt <= 0;
        else                                              wcnt <= wcnt + 1;
    end

    // Activity monitor, sampled on the falling edge.
    int          stall_cnt = 0, rd_cyc = 0, rdb = 0, wrb = 0, ovl = 0, done_cnt = 0;
    logic        prev_rd = 1'b0, prev_wr = 1'b0;
    logic [31:0] last_ra = '0, last_wa = '0, last_wd = '0;

    always @(negedge clk) begin
        prev_rd <= mem_read;
        prev_wr <= mem_write;
        if (stall)                 stall_cnt <= stall_cnt + 1;
        if (mem_read)              rd_cyc <= rd_cyc + 1;
        if (mem_read && !prev_rd)  rdb <= rdb + 1;
        if (mem_write && !prev_wr) wrb <= wrb + 1;
        if (mem_read && mem_write) ovl <= ovl + 1;
        if (done)                  done_cnt <= done_cnt + 1;
        if (mem_read && mem_ready) last_ra <= mem_addr;
        if (mem_write && mem_ready) begin
            last_wa <= mem_addr;
            last_wd <= mem_wdata;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Results of the most recent run_req.
    logic        s_done, s_err;
    logic [31:0] s_load;
    int          s_cyc, d_stall, d_rdc, d_rdb, d_wrb, d_ovl, d_done;

    // Present one request, hold it until done/err, then release it.
    task automatic run_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] lm,
                           input logic [1:0] sm, input int latency);
        int b_stall, b_rdc, b_rdb, b_wrb, b_ovl, b_done;
        logic got;
        @(posedge clk); #1;
        b_stall = stall_cnt; b_rdc = rd_cyc; b_rdb = rdb; b_wrb = wrb;
        b_ovl = ovl; b_done = done_cnt;
        lat = latency;
        req_read = rd; req_write = wr; req_addr = addr; req_wdata = wdata;
        load_mode = lm; store_mode = sm;
        got = 1'b0;
        s_cyc = 0;
        while (!got && s_cyc < 80) begin
            @(negedge clk);
            s_cyc++;
            if (done || err) begin
                got = 1'b1;
                s_done = done; s_err = err; s_load = load_data;
            end
        end
        if (!got) check("wait_done_or_err", 32'(got), 32'd1);
        @(posedge clk); #1;
        req_read = 1'b0; req_write = 1'b0;
        d_stall = stall_cnt - b_stall; d_rdc = rd_cyc - b_rdc;
        d_rdb = rdb - b_rdb; d_wrb = wrb - b_wrb;
        d_ovl = ovl - b_ovl; d_done = done_cnt - b_done;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int base_done;
        for (int i = 0; i < 16; i++) ram[i] = 32'h0;
        ram[4] = 32'hDEADBEEF;
        ram[8] = 32'h11223344;
        rst = 1'b1;
        req_read = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        load_mode = 2'b00; store_mode = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_done_err", {30'd0, done, err}, 32'd0);
        check("reset_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mem_wdata", mem_wdata, 32'h0);
        check("reset_load_data", load_data, 32'h0);
        rst = 1'b0;

        // Word load, ready on the third READ cycle.
        run_req(1'b1, 1'b0, 32'h10, 32'h0, 2'b00, 2'b00, 2);
        check("wl_done", 32'(s_done), 32'd1);
        check("wl_err", 32'(s_err), 32'd0);
        check("wl_data", s_load, 32'hDEADBEEF);
        check("wl_cycles", 32'(s_cyc), 32'd5);
        check("wl_stall_cycles", 32'(d_stall), 32'd4);
        check("wl_read_bursts", 32'(d_rdb), 32'd1);
        check("wl_write_bursts", 32'(d_wrb), 32'd0);
        check("wl_read_addr", last_ra, 32'h10);
        check("wl_done_pulses", 32'(d_done), 32'd1);

        // Sub-word loads from word 0x80FF7F01.
        ram[4] = 32'h80FF7F01;
        run_req(1'b1, 1'b0, 32'h13, 32'h0, 2'b10, 2'b00, 0);
        check("lb_13", s_load, 32'hFFFFFF80);
        run_req(1'b1, 1'b0, 32'h13, 32'h0, 2'b11, 2'b00, 0);
        check("lbu_13", s_load, 32'h00000080);
        run_req(1'b1, 1'b0, 32'h12, 32'h0, 2'b01, 2'b00, 0);
        check("lh_12", s_load, 32'hFFFF80FF);
        run_req(1'b1, 1'b0, 32'h11, 32'h0, 2'b10, 2'b00, 1);
        check("lb_11", s_load, 32'h0000007F);
        check("lb_11_done", 32'(s_done), 32'd1);

        // RAM never answers: abandon after 16 wait cycles.
        run_req(1'b1, 1'b0, 32'h10, 32'h0, 2'b00, 2'b00, -1);
        check("to_done_err", {30'd0, s_done, s_err}, 32'd3);
        check("to_read_cycles", 32'(d_rdc), 32'd16);
        check("to_cycles", 32'(s_cyc), 32'd18);
        check("to_load_kept", s_load, 32'h0000007F);

        // Byte store read-modify-write.
        run_req(1'b0, 1'b1, 32'h21, 32'hAB, 2'b00, 2'b10, 1);
        check("sb_done", {30'd0, s_done, s_err}, 32'd2);
        check("sb_wdata", last_wd, 32'h1122AB44);
        check("sb_waddr", last_wa, 32'h20);
        check("sb_read_bursts", 32'(d_rdb), 32'd1);
        check("sb_write_bursts", 32'(d_wrb), 32'd1);
        check("sb_overlap", 32'(d_ovl), 32'd0);
        check("sb_stall_cycles", 32'(d_stall), 32'd5);

        // Halfword store RMW and plain word store.
        run_req(1'b0, 1'b1, 32'h22, 32'h0000BEEF, 2'b00, 2'b01, 0);
        check("sh_wdata", last_wd, 32'hBEEF3344);
        check("sh_overlap", 32'(d_ovl), 32'd0);
        run_req(1'b0, 1'b1, 32'h24, 32'hCAFEF00D, 2'b00, 2'b00, 2);
        check("sw_wdata", last_wd, 32'hCAFEF00D);
        check("sw_waddr", last_wa, 32'h24);
        check("sw_read_bursts", 32'(d_rdb), 32'd0);
        check("sw_write_bursts", 32'(d_wrb), 32'd1);

        // Rejected requests: err only, no RAM traffic, no stall.
        run_req(1'b1, 1'b0, 32'h02, 32'h0, 2'b00, 2'b00, 0);
        check("mis_lw_err_done", {30'd0, s_done, s_err}, 32'd1);
        check("mis_lw_cycles", 32'(s_cyc), 32'd2);
        check("mis_lw_stall", 32'(d_stall), 32'd0);
        check("mis_lw_strobes", 32'(d_rdb + d_wrb), 32'd0);
        check("mis_lw_load_kept", s_load, 32'h0000007F);
        run_req(1'b1, 1'b1, 32'h10, 32'h0, 2'b00, 2'b00, 0);
        check("both_err_done", {30'd0, s_done, s_err}, 32'd1);
        check("both_strobes", 32'(d_rdb + d_wrb), 32'd0);
        check("both_stall", 32'(d_stall), 32'd0);
        run_req(1'b0, 1'b1, 32'h10, 32'h0, 2'b00, 2'b11, 0);
        check("sm11_err_done", {30'd0, s_done, s_err}, 32'd1);
        check("sm11_strobes", 32'(d_rdb + d_wrb), 32'd0);
        run_req(1'b0, 1'b1, 32'h21, 32'h0, 2'b00, 2'b01, 0);
        check("mis_sh_err_done", {30'd0, s_done, s_err}, 32'd1);
        check("mis_sh_strobes", 32'(d_rdb + d_wrb), 32'd0);

        // Reset while the RMW write is outstanding.
        @(posedge clk); #1;
        lat = 5;
        base_done = done_cnt;
        req_write = 1'b1; req_addr = 32'h21; req_wdata = 32'h55; store_mode = 2'b10;
        n = 0;
        while (!mem_write && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rmw_wr_reached", 32'(mem_write), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_mid_stall", 32'(stall), 32'd0);
        check("rst_mid_load_data", load_data, 32'h0);
        repeat (2) @(negedge clk);
        req_write = 1'b0; store_mode = 2'b00;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_no_done", 32'(done_cnt - base_done), 32'd0);

        // Normal operation afterwards.
        run_req(1'b1, 1'b0, 32'h10, 32'h0, 2'b00, 2'b00, 1);
        check("post_rst_load", s_load, 32'h80FF7F01);
        check("post_rst_done_err", {30'd0, s_done, s_err}, 32'd2);
        check("post_rst_stall", 32'(d_stall), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
